// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte write enables, selectable same-port write mode,
// read-valid strobes, cross-port collision flag and a post-reset clear sequencer.
module ram_tdp_be #(
  parameter int    cRamWidth       = 32,
  parameter int    cByteWidth      = 8,
  parameter int    cRamDepth       = 1024,
  parameter string cRamPerformance = "HIGH_PERFORMANCE",
  parameter string cWriteMode      = "READ_FIRST",
  parameter bit    cClearOnReset   = 1'b1,
  localparam int   nBytes          = cRamWidth / cByteWidth,
  localparam int   aw              = $clog2(cRamDepth)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  output logic                 oReady,
  input  logic                 iEnA,
  input  logic [nBytes-1:0]    iWEnA,
  input  logic [aw-1:0]        iAddrA,
  input  logic [cRamWidth-1:0] iDataA,
  output logic [cRamWidth-1:0] oDataA,
  output logic                 oValidA,
  input  logic                 iEnB,
  input  logic [nBytes-1:0]    iWEnB,
  input  logic [aw-1:0]        iAddrB,
  input  logic [cRamWidth-1:0] iDataB,
  output logic [cRamWidth-1:0] oDataB,
  output logic                 oValidB,
  output logic                 oCollision
);

  localparam bit cHighPerf   = (cRamPerformance == "HIGH_PERFORMANCE");
  localparam bit cWriteFirst = (cWriteMode == "WRITE_FIRST");
  localparam bit cNoChange   = (cWriteMode == "NO_CHANGE");

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  state_t               state, stateNext;
  logic [aw-1:0]        clearAddr, clearAddrNext;
  logic                 clearWe;
  logic                 ready;
  logic [cRamWidth-1:0] mem [cRamDepth];

  logic                 accA, accB, wrA, wrB, emitA, emitB;
  logic [cRamWidth-1:0] rdA, rdB, firstA, firstB;
  logic                 s1ValidA, s1ValidB;
  logic [cRamWidth-1:0] s1DataA, s1DataB;

  function automatic logic [cRamWidth-1:0] mergeLanes(input logic [cRamWidth-1:0] oldWord,
                                                      input logic [cRamWidth-1:0] newWord,
                                                      input logic [nBytes-1:0] wen);
    logic [cRamWidth-1:0] res;
    res = oldWord;
    for (int k = 0; k < nBytes; k++)
      if (wen[k]) res[k*cByteWidth +: cByteWidth] = newWord[k*cByteWidth +: cByteWidth];
    return res;
  endfunction

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      clearAddr <= '0;
    end else begin
      state     <= stateNext;
      clearAddr <= clearAddrNext;
    end
  end

  // IDLE lasts one cycle after reset; CLEAR zeroes one word per cycle.
  always_comb begin
    stateNext     = state;
    clearAddrNext = clearAddr;
    clearWe       = 1'b0;
    unique case (state)
      IDLE: begin
        clearAddrNext = '0;
        stateNext     = cClearOnReset ? CLEAR : RUN;
      end
      CLEAR: begin
        clearWe = 1'b1;
        if (clearAddr == aw'(cRamDepth - 1)) stateNext = RUN;
        else clearAddrNext = clearAddr + 1'b1;
      end
      RUN: ;
      default: stateNext = IDLE;
    endcase
  end

  assign ready  = (state == RUN);
  assign oReady = ready;

  assign accA   = iEnA && ready && !iRst && (int'(iAddrA) < cRamDepth);
  assign accB   = iEnB && ready && !iRst && (int'(iAddrB) < cRamDepth);
  assign wrA    = accA && (|iWEnA);
  assign wrB    = accB && (|iWEnB);
  assign emitA  = accA && !(wrA && cNoChange);
  assign emitB  = accB && !(wrB && cNoChange);
  assign rdA    = mem[iAddrA];
  assign rdB    = mem[iAddrB];
  assign firstA = mergeLanes(rdA, iDataA, iWEnA);
  assign firstB = mergeLanes(rdB, iDataB, iWEnB);

  // Port A lanes are assigned last so they win on overlapping lanes.
  always_ff @(posedge iClk) begin
    if (clearWe && !iRst) mem[clearAddr] <= '0;
    for (int k = 0; k < nBytes; k++)
      if (wrB && iWEnB[k])
        mem[iAddrB][k*cByteWidth +: cByteWidth] <= iDataB[k*cByteWidth +: cByteWidth];
    for (int k = 0; k < nBytes; k++)
      if (wrA && iWEnA[k])
        mem[iAddrA][k*cByteWidth +: cByteWidth] <= iDataA[k*cByteWidth +: cByteWidth];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1ValidA   <= 1'b0;
      s1ValidB   <= 1'b0;
      s1DataA    <= '0;
      s1DataB    <= '0;
      oCollision <= 1'b0;
    end else begin
      s1ValidA   <= emitA;
      s1ValidB   <= emitB;
      if (emitA) s1DataA <= (wrA && cWriteFirst) ? firstA : rdA;
      if (emitB) s1DataB <= (wrB && cWriteFirst) ? firstB : rdB;
      oCollision <= accA && accB && (iAddrA == iAddrB) && (wrA || wrB);
    end
  end

  generate
    if (cHighPerf) begin : gOutReg
      logic                 s2ValidA, s2ValidB;
      logic [cRamWidth-1:0] s2DataA, s2DataB;

      always_ff @(posedge iClk) begin
        if (iRst) begin
          s2ValidA <= 1'b0;
          s2ValidB <= 1'b0;
          s2DataA  <= '0;
          s2DataB  <= '0;
        end else begin
          s2ValidA <= s1ValidA;
          s2ValidB <= s1ValidB;
          if (s1ValidA) s2DataA <= s1DataA;
          if (s1ValidB) s2DataB <= s1DataB;
        end
      end

      assign oValidA = s2ValidA;
      assign oValidB = s2ValidB;
      assign oDataA  = s2DataA;
      assign oDataB  = s2DataB;
    end else begin : gNoOutReg
      assign oValidA = s1ValidA;
      assign oValidB = s1ValidB;
      assign oDataA  = s1DataA;
      assign oDataB  = s1DataB;
    end
  endgenerate

endmodule
